issue_hazard_ctrl: RTL

- Issue-stage controller sitting between the decode stage and the functional units, directly upstream of the register scoreboard.
- Holds one decoded instruction and checks its operands against the scoreboard through the scoreboard's single asynchronous lookup port: rs, then rt, then rd (WAW).
- Stalls until all three checks are clear, then issues downstream and claims rd in the scoreboard on the same edge.

---
 rtl/issue_hazard_ctrl_pkg.sv | 39 +++
 rtl/issue_hazard_ctrl_hazard_check.sv | 17 +
 rtl/issue_hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared types and constants for the issue-stage hazard controller.
package issue_hazard_ctrl_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned UNIT_W = 2;
   localparam int unsigned SB_W   = 8;

   // Scoreboard row layout
   localparam int unsigned PEND_BIT = 7;
   localparam int unsigned UNIT_MSB = 6;
   localparam int unsigned UNIT_LSB = 5;
   localparam int unsigned POS_MSB  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHK_RS = 3'd1,
      CHK_RT = 3'd2,
      CHK_RD = 3'd3,
      ISSUE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      STALL_NONE = 2'd0,
      STALL_RS   = 2'd1,
      STALL_RT   = 2'd2,
      STALL_RD   = 2'd3
   } stall_t;

   typedef struct packed {
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic              use_rs;
      logic              use_rt;
      logic              write_rd;
      logic [UNIT_W-1:0] unit;
   } instr_hdr_t;

endpackage

// File: rtl/issue_hazard_ctrl_hazard_check.sv
// Single operand hazard test against one scoreboard row; register 0 never conflicts.
module issue_hazard_ctrl_hazard_check
   import issue_hazard_ctrl_pkg::*;
(
   input  logic             use_reg,
   input  logic [REG_W-1:0] reg_idx,
   input  logic [SB_W-1:0]  sb_data,
   output logic             clear_c
);

   // Only the pending bit matters here; unit and position are informational.
   logic unused_row;
   assign unused_row = ^sb_data[UNIT_MSB:0];

   assign clear_c = ~use_reg | (reg_idx == '0) | ~sb_data[PEND_BIT];

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue-stage controller: holds one instruction, checks rs/rt/rd against the
// scoreboard in turn, then issues and claims rd on the handshake edge.
module issue_hazard_ctrl
   import issue_hazard_ctrl_pkg::*;
#(
   parameter int unsigned PAYLOAD_W = 32,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4:0]           in_rs,
   input  logic [4:0]           in_rt,
   input  logic [4:0]           in_rd,
   input  logic                 in_use_rs,
   input  logic                 in_use_rt,
   input  logic                 in_write_rd,
   input  logic [1:0]           in_unit,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic [4:0]           sb_addr,
   input  logic [7:0]           sb_data,
   output logic [4:0]           sb_writeaddr,
   output logic [1:0]           sb_registerstage,
   output logic                 sb_enablewrite,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4:0]           out_rs,
   output logic [4:0]           out_rt,
   output logic [4:0]           out_rd,
   output logic [1:0]           out_unit,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [1:0]           stall_reason,
   output logic [CNT_W-1:0]     stall_cycles
);

   state_t               state_q, state_d;
   instr_hdr_t           hdr_q;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [CNT_W-1:0]     cnt_q;

   logic             chk_use;
   logic [REG_W-1:0] chk_reg;
   logic             chk_clear;
   logic             accept;
   logic             stay;

   // Lookup operand selected by the current check state
   always_comb begin
      chk_use = hdr_q.use_rs;
      chk_reg = hdr_q.rs;
      case (state_q)
         CHK_RT: begin
            chk_use = hdr_q.use_rt;
            chk_reg = hdr_q.rt;
         end
         CHK_RD: begin
            chk_use = hdr_q.write_rd;
            chk_reg = hdr_q.rd;
         end
         default: ;
      endcase
   end

   assign sb_addr = chk_reg;

   issue_hazard_ctrl_hazard_check u_hazard_check (
      .use_reg (chk_use),
      .reg_idx (chk_reg),
      .sb_data (sb_data),
      .clear_c (chk_clear)
   );

   // Next state, handshakes and scoreboard claim
   always_comb begin
      state_d          = state_q;
      in_ready         = 1'b0;
      out_valid        = 1'b0;
      stall_reason     = STALL_NONE;
      sb_enablewrite   = 1'b0;
      sb_writeaddr     = '0;
      sb_registerstage = '0;
      accept           = 1'b0;
      stay             = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = CHK_RS;
            end
         end
         CHK_RS: begin
            if (chk_clear) state_d = CHK_RT;
            else begin
               stall_reason = STALL_RS;
               stay         = 1'b1;
            end
         end
         CHK_RT: begin
            if (chk_clear) state_d = CHK_RD;
            else begin
               stall_reason = STALL_RT;
               stay         = 1'b1;
            end
         end
         CHK_RD: begin
            if (chk_clear) state_d = ISSUE;
            else begin
               stall_reason = STALL_RD;
               stay         = 1'b1;
            end
         end
         ISSUE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               sb_enablewrite   = hdr_q.write_rd && (hdr_q.rd != '0);
               sb_writeaddr     = hdr_q.rd;
               sb_registerstage = hdr_q.unit;
               if (in_valid) begin
                  accept  = 1'b1;
                  state_d = CHK_RS;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Flush overrides everything: no issue, no claim, no accept, no stall count
      if (flush) begin
         state_d        = IDLE;
         in_ready       = 1'b0;
         out_valid      = 1'b0;
         sb_enablewrite = 1'b0;
         stall_reason   = STALL_NONE;
         accept         = 1'b0;
         stay           = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hdr_q     <= '0;
         payload_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            hdr_q.rs       <= in_rs;
            hdr_q.rt       <= in_rt;
            hdr_q.rd       <= in_rd;
            hdr_q.use_rs   <= in_use_rs;
            hdr_q.use_rt   <= in_use_rt;
            hdr_q.write_rd <= in_write_rd;
            hdr_q.unit     <= in_unit;
            payload_q      <= in_payload;
         end
         if (stay && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_rs       = hdr_q.rs;
   assign out_rt       = hdr_q.rt;
   assign out_rd       = hdr_q.rd;
   assign out_unit     = hdr_q.unit;
   assign out_payload  = payload_q;
   assign stall_cycles = cnt_q;

endmodule
